// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and constants for the latch register file write path
package rf_pkg;

    localparam int RF_W     = 32;
    localparam int RF_AW    = 5;
    localparam int ONEHOT_W = 2 ** RF_AW;

    typedef enum logic [2:0] {
        INIT_SETUP,
        INIT_PULSE,
        IDLE,
        SETUP,
        PULSE
    } rf_wr_state_t;

endpackage

// File: rtl/rf_onehot_dec.sv
// rtl/rf_onehot_dec.sv - binary to one-hot decoder with enable
module rf_onehot_dec #(
    parameter int AW = 5
) (
    input  logic                en,
    input  logic [AW-1:0]       addr,
    output logic [(2**AW)-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_latch_wr_seq.sv
// rtl/rf_latch_wr_seq.sv - write sequencer driving registered one-hot latch enables
module rf_latch_wr_seq
    import rf_pkg::*;
#(
    parameter int W       = RF_W,
    parameter int AW      = RF_AW,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                clk,
    input  logic                a_reset_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [AW-1:0]       wr_addr,
    input  logic [W-1:0]        wr_data,
    output logic [(2**AW)-1:0]  lat_en,
    output logic [W-1:0]        lat_data,
    output logic                fwd_valid,
    output logic [AW-1:0]       fwd_addr,
    output logic [W-1:0]        fwd_data,
    output logic                init_done
);

    rf_wr_state_t          state;
    logic [AW-1:0]         init_cnt;
    logic [AW-1:0]         stg_addr;
    logic                  dec_en;
    logic [AW-1:0]         dec_addr;
    logic [(2**AW)-1:0]    dec_onehot;
    logic                  accept;

    // The decoder looks one state ahead so its output lands in lat_en on the PULSE edge.
    always_comb begin
        dec_en   = (state == INIT_SETUP) || (state == SETUP);
        dec_addr = (state == INIT_SETUP) ? init_cnt : stg_addr;
    end

    rf_onehot_dec #(
        .AW(AW)
    ) u_dec (
        .en     (dec_en),
        .addr   (dec_addr),
        .onehot (dec_onehot)
    );

    assign accept   = wr_valid && wr_ready;
    assign fwd_addr = stg_addr;
    assign fwd_data = lat_data;

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state     <= INIT_SETUP;
            init_cnt  <= '0;
            stg_addr  <= '0;
            lat_en    <= '0;
            lat_data  <= '0;
            wr_ready  <= 1'b0;
            fwd_valid <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT_SETUP: begin
                    lat_en <= dec_onehot;
                    state  <= INIT_PULSE;
                end
                INIT_PULSE: begin
                    lat_en <= '0;
                    if (init_cnt != {AW{1'b1}}) begin
                        init_cnt <= init_cnt + 1'b1;
                        state    <= INIT_SETUP;
                    end else begin
                        init_done <= 1'b1;
                        wr_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                IDLE: begin
                    lat_en <= '0;
                    // Writes to x0 are swallowed here; the sweep already zeroed it.
                    if (accept && !(ZERO_R0 && (wr_addr == '0))) begin
                        stg_addr  <= wr_addr;
                        lat_data  <= wr_data;
                        fwd_valid <= 1'b1;
                        wr_ready  <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    lat_en <= dec_onehot;
                    state  <= PULSE;
                end
                PULSE: begin
                    lat_en    <= '0;
                    fwd_valid <= 1'b0;
                    wr_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    lat_en <= '0;
                    state  <= INIT_SETUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_latch_wr_seq.sv
// tb/tb_rf_latch_wr_seq.sv - directed self-checking bench for rf_latch_wr_seq
module tb_rf_latch_wr_seq;

    localparam int W  = 32;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              a_reset_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr = '0;
    logic [W-1:0]      wr_data = '0;
    logic [31:0]       lat_en;
    logic [W-1:0]      lat_data;
    logic              fwd_valid;
    logic [AW-1:0]     fwd_addr;
    logic [W-1:0]      fwd_data;
    logic              init_done;

    int total = 0;
    int bad   = 0;
    logic        mon_en = 1'b0;
    logic [31:0] prev_en = '0;
    logic [W-1:0] prev_data = '0;

    rf_latch_wr_seq #(
        .W(W),
        .AW(AW),
        .ZERO_R0(1'b1)
    ) dut (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .lat_en    (lat_en),
        .lat_data  (lat_data),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Latch data must be stable whenever an enable is high or has just fallen.
    always @(negedge clk) begin
        if (mon_en) begin
            check("lat_en_onehot", 64'($countones(lat_en) <= 1), 64'd1);
            if (lat_en != '0 || prev_en != '0) begin
                check("lat_data_stable", 64'(lat_data), 64'(prev_data));
            end
        end
        prev_en   = lat_en;
        prev_data = lat_data;
    end

    task automatic run_sweep();
        for (int cyc = 1; cyc <= 64; cyc++) begin
            step();
            check("sweep_en", 64'(lat_en), (cyc % 2 == 1) ? (64'd1 << ((cyc - 1) / 2)) : 64'd0);
            check("sweep_data", 64'(lat_data), 64'd0);
            check("sweep_done", 64'(init_done), 64'(cyc == 64));
            check("sweep_ready", 64'(wr_ready), 64'(cyc == 64));
        end
    endtask

    initial begin
        #12;
        check("rst_en", 64'(lat_en), 64'd0);
        check("rst_data", 64'(lat_data), 64'd0);
        check("rst_ready", 64'(wr_ready), 64'd0);
        check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        check("rst_fwd_addr", 64'(fwd_addr), 64'd0);
        check("rst_fwd_data", 64'(fwd_data), 64'd0);
        check("rst_done", 64'(init_done), 64'd0);

        // Request to addr 9 pending throughout the sweep.
        wr_valid = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'hA5A5_0009;
        @(negedge clk);
        a_reset_n = 1'b1;
        #1 mon_en = 1'b1;
        run_sweep();

        step();
        wr_valid = 1'b0;
        check("a9_setup_data", 64'(lat_data), 64'hA5A5_0009);
        check("a9_setup_en", 64'(lat_en), 64'd0);
        check("a9_setup_fwd", 64'(fwd_valid), 64'd1);
        check("a9_setup_addr", 64'(fwd_addr), 64'd9);
        step();
        check("a9_pulse_en", 64'(lat_en), 64'h200);
        check("a9_pulse_ready", 64'(wr_ready), 64'd0);
        step();
        check("a9_idle_en", 64'(lat_en), 64'd0);
        check("a9_idle_ready", 64'(wr_ready), 64'd1);
        check("a9_idle_fwd", 64'(fwd_valid), 64'd0);

        // Single write addr 5.
        wr_valid = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = 32'hDEAD_BEEF;
        step();
        wr_valid = 1'b0;
        check("w5_setup_data", 64'(lat_data), 64'hDEAD_BEEF);
        check("w5_setup_en", 64'(lat_en), 64'd0);
        check("w5_setup_fwd", 64'(fwd_valid), 64'd1);
        check("w5_setup_addr", 64'(fwd_addr), 64'd5);
        check("w5_setup_fdata", 64'(fwd_data), 64'hDEAD_BEEF);
        step();
        check("w5_pulse_en", 64'(lat_en), 64'h20);
        check("w5_pulse_fwd", 64'(fwd_valid), 64'd1);
        step();
        check("w5_idle_en", 64'(lat_en), 64'd0);
        check("w5_idle_data", 64'(lat_data), 64'hDEAD_BEEF);
        check("w5_idle_ready", 64'(wr_ready), 64'd1);

        // Back-to-back: addr 3 then addr 7 with wr_valid held.
        wr_valid = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 32'h0000_0033;
        step();
        check("b2b_a3_setup", 64'(fwd_addr), 64'd3);
        check("b2b_a3_ready", 64'(wr_ready), 64'd0);
        wr_addr = 5'd7;
        wr_data = 32'h0000_0077;
        step();
        check("b2b_a3_pulse", 64'(lat_en), 64'h8);
        check("b2b_a3_hold", 64'(lat_data), 64'h33);
        step();
        check("b2b_idle_ready", 64'(wr_ready), 64'd1);
        check("b2b_idle_en", 64'(lat_en), 64'd0);
        step();
        wr_valid = 1'b0;
        check("b2b_a7_setup_fwd", 64'(fwd_valid), 64'd1);
        check("b2b_a7_setup_addr", 64'(fwd_addr), 64'd7);
        check("b2b_a7_setup_data", 64'(lat_data), 64'h77);
        step();
        check("b2b_a7_pulse", 64'(lat_en), 64'h80);
        step();

        // Dropped write to x0 followed immediately by addr 4.
        wr_valid = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'h0000_1234;
        step();
        check("r0_ready", 64'(wr_ready), 64'd1);
        check("r0_fwd", 64'(fwd_valid), 64'd0);
        check("r0_en", 64'(lat_en), 64'd0);
        check("r0_data", 64'(lat_data), 64'h77);
        wr_addr = 5'd4;
        wr_data = 32'h0000_0044;
        step();
        wr_valid = 1'b0;
        check("r0_next_fwd", 64'(fwd_valid), 64'd1);
        check("r0_next_addr", 64'(fwd_addr), 64'd4);
        step();
        check("r0_next_pulse", 64'(lat_en), 64'h10);
        step();
        check("r0_next_idle", 64'(lat_en), 64'd0);

        // Reset in the middle of a PULSE to addr 12.
        wr_valid = 1'b1;
        wr_addr  = 5'd12;
        wr_data  = 32'h0000_000C;
        step();
        wr_valid = 1'b0;
        step();
        check("a12_pulse_en", 64'(lat_en), 64'h1000);
        mon_en = 1'b0;
        #2 a_reset_n = 1'b0;
        #1;
        check("arst_en", 64'(lat_en), 64'd0);
        check("arst_done", 64'(init_done), 64'd0);
        check("arst_ready", 64'(wr_ready), 64'd0);
        check("arst_fwd", 64'(fwd_valid), 64'd0);
        @(negedge clk);
        a_reset_n = 1'b1;
        #1 mon_en = 1'b1;
        run_sweep();
        check("resweep_fwd", 64'(fwd_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
